// File: rtl/md_gradient_if.sv
// Window stream in, block mode decision out, for the intra mode-decision Sobel stage.
interface md_gradient_if;
   logic        start;
   logic        win_valid;
   logic [23:0] x1;
   logic [15:0] x2;
   logic [23:0] x3;
   logic        busy;
   logic        mode_valid;
   logic [5:0]  mode;
   logic [16:0] sum_ver;
   logic [16:0] sum_hor;
   logic [16:0] sum_d18;
   logic [16:0] sum_d34;

   modport master (
      output start, win_valid, x1, x2, x3,
      input  busy, mode_valid, mode, sum_ver, sum_hor, sum_d18, sum_d34
   );

   modport slave (
      input  start, win_valid, x1, x2, x3,
      output busy, mode_valid, mode, sum_ver, sum_hor, sum_d18, sum_d34
   );
endinterface

// File: rtl/md_gradient.sv
// Sobel gradient per 3x3 window, magnitude-weighted direction histogram per 8x8 block,
// and one coarse HEVC intra mode per block.
module md_gradient #(
   parameter int unsigned NUM_WIN = 36,
   parameter int unsigned MAG_THR = 16,
   parameter int unsigned SUM_THR = 512
) (
   input logic          clk,
   input logic          rstn,
   md_gradient_if.slave bus
);

   localparam int unsigned CntW = $clog2(NUM_WIN + 1);

   localparam logic [1:0] BinVer = 2'd0;
   localparam logic [1:0] BinHor = 2'd1;
   localparam logic [1:0] BinD18 = 2'd2;
   localparam logic [1:0] BinD34 = 2'd3;

   typedef enum logic [1:0] {StIdle, StAcc, StDecide} state_e;

   state_e         state_q;
   logic           busy_q;
   logic           mode_valid_q;
   logic [5:0]     mode_q;
   logic [16:0]    sum_ver_q, sum_hor_q, sum_d18_q, sum_d34_q;
   logic [CntW-1:0] cnt_q;

   // S0: sampled window
   logic           s0_valid;
   logic [7:0]     p00, p01, p02, p10, p12, p20, p21, p22;
   // S1: gradients (two's complement, 11 bits)
   logic           s1_valid;
   logic [10:0]    gx_q, gy_q;
   // S2: magnitude and bin
   logic           s2_valid;
   logic [10:0]    mag_q;
   logic [1:0]     bin_q;

   logic [10:0]    gx_c, gy_c, ax_c, ay_c, mag_c;
   logic [12:0]    ax2_c, ay2_c, ax5_c, ay5_c;
   logic [1:0]     bin_c;
   logic [16:0]    best_c;
   logic [5:0]     mode_c;
   logic           vote;

   always_comb begin
      gx_c = ({3'b0, p02} + {2'b0, p12, 1'b0} + {3'b0, p22})
           - ({3'b0, p00} + {2'b0, p10, 1'b0} + {3'b0, p20});
      gy_c = ({3'b0, p20} + {2'b0, p21, 1'b0} + {3'b0, p22})
           - ({3'b0, p00} + {2'b0, p01, 1'b0} + {3'b0, p02});
   end

   always_comb begin
      ax_c  = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
      ay_c  = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
      mag_c = ax_c + ay_c;
      ax2_c = {1'b0, ax_c, 1'b0};
      ay2_c = {1'b0, ay_c, 1'b0};
      ax5_c = {ax_c, 2'b00} + {2'b00, ax_c};
      ay5_c = {ay_c, 2'b00} + {2'b00, ay_c};
      // Slopes shallower than 2/5 count as axis-aligned, the rest are diagonal.
      if (ay5_c <= ax2_c) begin
         bin_c = BinVer;
      end else if (ax5_c <= ay2_c) begin
         bin_c = BinHor;
      end else if (gx_q[10] == gy_q[10]) begin
         bin_c = BinD34;
      end else begin
         bin_c = BinD18;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s0_valid <= 1'b0;
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         {p00, p01, p02} <= '0;
         {p10, p12}      <= '0;
         {p20, p21, p22} <= '0;
         gx_q  <= '0;
         gy_q  <= '0;
         mag_q <= '0;
         bin_q <= BinVer;
      end else begin
         s0_valid <= bus.win_valid && (state_q == StAcc) && !bus.start;
         s1_valid <= s0_valid && !bus.start;
         s2_valid <= s1_valid && !bus.start;
         if (bus.win_valid) begin
            {p00, p01, p02} <= bus.x1;
            {p10, p12}      <= bus.x2;
            {p20, p21, p22} <= bus.x3;
         end
         gx_q  <= gx_c;
         gy_q  <= gy_c;
         mag_q <= mag_c;
         bin_q <= bin_c;
      end
   end

   assign vote = (mag_q >= 11'(MAG_THR));

   // Strict > keeps the earlier bin on ties: VER > HOR > D18 > D34.
   always_comb begin
      best_c = sum_ver_q;
      mode_c = 6'd26;
      if (sum_hor_q > best_c) begin
         best_c = sum_hor_q;
         mode_c = 6'd10;
      end
      if (sum_d18_q > best_c) begin
         best_c = sum_d18_q;
         mode_c = 6'd18;
      end
      if (sum_d34_q > best_c) begin
         best_c = sum_d34_q;
         mode_c = 6'd34;
      end
      if (best_c < 17'(SUM_THR)) begin
         mode_c = 6'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         busy_q       <= 1'b0;
         mode_valid_q <= 1'b0;
         mode_q       <= '0;
         sum_ver_q    <= '0;
         sum_hor_q    <= '0;
         sum_d18_q    <= '0;
         sum_d34_q    <= '0;
         cnt_q        <= '0;
      end else begin
         mode_valid_q <= 1'b0;
         if (bus.start) begin
            state_q   <= StAcc;
            busy_q    <= 1'b1;
            sum_ver_q <= '0;
            sum_hor_q <= '0;
            sum_d18_q <= '0;
            sum_d34_q <= '0;
            cnt_q     <= '0;
         end else begin
            case (state_q)
               StIdle: ;
               StAcc: begin
                  if (s2_valid) begin
                     if (vote) begin
                        unique case (bin_q)
                           BinVer: sum_ver_q <= sum_ver_q + {6'b0, mag_q};
                           BinHor: sum_hor_q <= sum_hor_q + {6'b0, mag_q};
                           BinD18: sum_d18_q <= sum_d18_q + {6'b0, mag_q};
                           BinD34: sum_d34_q <= sum_d34_q + {6'b0, mag_q};
                        endcase
                     end
                     cnt_q <= cnt_q + 1'b1;
                     if (cnt_q == CntW'(NUM_WIN - 1)) begin
                        state_q <= StDecide;
                     end
                  end
               end
               StDecide: begin
                  mode_q       <= mode_c;
                  mode_valid_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.busy       = busy_q;
   assign bus.mode_valid = mode_valid_q;
   assign bus.mode       = mode_q;
   assign bus.sum_ver    = sum_ver_q;
   assign bus.sum_hor    = sum_hor_q;
   assign bus.sum_d18    = sum_d18_q;
   assign bus.sum_d34    = sum_d34_q;

endmodule

// File: doc/md_gradient.md
# md_gradient

Downstream consumer of the intra mode-decision fetch stage. Takes the stream of 3x3 luma windows (top row 3 pixels, middle row 2 side pixels, bottom row 3 pixels) and computes a Sobel gradient for each window. It builds a magnitude-weighted direction histogram over one 8x8 block (36 windows) and emits one coarse intra prediction mode per block to the mode-decision controller.

## Interface
- NUM_WIN, 36, windows per block
- MAG_THR, 16, minimum |gx|+|gy| for a window to vote
- SUM_THR, 512, minimum winning-bin sum; below this the block is declared flat
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; clears histogram and counters, begins a block
- win_valid  in  1  x1/x2/x3 hold a valid window this cycle
- x1  in  24  {p00,p01,p02}, MSB-first, unsigned 8-bit pixels
- x2  in  16  {p10,p12}
- x3  in  24  {p20,p21,p22}
- busy  out  1  high from start until mode_valid
- mode_valid  out  1  one-cycle pulse, mode and bin sums valid
- mode  out  6  HEVC intra mode: 1 DC, 10 HOR, 26 VER, 18, 34
- sum_ver, sum_hor, sum_d18, sum_d34  out  17 each  final bin sums (held until next start)

## Operation
- FSM states: IDLE, ACC, DECIDE.
  - IDLE + start -> ACC.
  - ACC with result count == NUM_WIN -> DECIDE.
  - DECIDE -> IDLE after one cycle, registering mode and pulsing mode_valid.
- start in any state clears bins, counters and the pipeline valids, then enters ACC. An in-flight block is abandoned and no mode_valid is produced for it.
- win_valid is ignored in IDLE and DECIDE. Gaps in win_valid are allowed.
- S1 (registered), 11-bit signed:
  - gx = (p02+2p12+p22) - (p00+2p10+p20)
  - gy = (p20+2p21+p22) - (p00+2p01+p02)
- S2 (registered):
  - ax=|gx|, ay=|gy|, mag=ax+ay (11-bit unsigned, max 2040).
  - Bin select: 5·ay <= 2·ax -> VER; else 5·ax <= 2·ay -> HOR; else gx, gy same sign -> D34; else D18.
  - ax=ay=0 always gives VER, but such a window never votes because mag < MAG_THR.
- S3: if mag >= MAG_THR, add mag to the selected 17-bit bin. This addition cannot overflow: 36·2040 = 73440. The result counter increments for every S2-valid window, voting or not.
- DECIDE: take the max bin, with tie priority VER > HOR > D18 > D34. If the max is < SUM_THR, mode = 1 (DC). Otherwise mode = 26/10/18/34 respectively.

## Timing
- Reset: busy=0, mode_valid=0, mode=0, all sums=0, state IDLE, pipeline valids 0.
- Per-window latency: sampled at edge E0, gx/gy at E1, bin/mag at E2, bin updated at E3.
- If the last window is sampled at E0, state enters DECIDE at E3. mode_valid and mode are registered at E4, so mode_valid is high for exactly the cycle after E4. busy falls at E4.
- Throughput: one window per clock, back-to-back.
- start and win_valid in the same cycle: start wins and that window is dropped.
- Reset mid-block: everything returns to reset values immediately and no pulse is produced.

## Test plan
- Flat: start, then 36 windows, all pixels 128 -> gx=gy=0, all sums 0, mode=1, mode_valid 4 clocks after the last window.
- Vertical edge: x1=x3={0,0,200}, x2={0,200}, 36 windows -> gx=800, gy=0, sum_ver=28800, mode=26.
- Horizontal edge: x1={0,0,0}, x2={0,0}, x3={200,200,200} -> gy=800, sum_hor=28800, mode=10.
- Diagonal: x1={0,0,100}, x2={0,100}, x3={100,100,100} -> gx=gy=300, sum_d34=21600, mode=34. Mirror the pattern left-right -> mode=18.
- Threshold/ties: 18 VER windows with mag 400 plus 18 HOR windows with mag 400 -> tie, mode=26. Windows with mag 10 only -> no votes, mode=1.
- Control: insert random win_valid gaps -> same result as back-to-back. Pulse start after 20 windows, then feed 36 -> exactly one mode_valid, sums reflect only the last 36. Assert rstn mid-block -> outputs return to 0.
